// File: rtl/compare_sequencer.sv
// compare_sequencer: multi-cycle unsigned magnitude comparator.
// A single 2-bit comparator is stepped over the latched operands, most
// significant slice first, and the walk stops at the first unequal slice.
// A start handshake feeds operands in and a done handshake hands the result out.

module two_bit_comparator (
    input  logic [1:0] A,
    input  logic [1:0] B,
    output logic       A_equal_B,
    output logic       A_greater_B,
    output logic       B_greater_A
);

    assign A_equal_B   = (A == B);
    assign A_greater_B = (A > B);
    assign B_greater_A = (B > A);

endmodule

module compare_sequencer #(
    parameter int WIDTH = 8,
    parameter int SW    = $clog2(WIDTH / 2) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             A_equal_B,
    output logic             A_greater_B,
    output logic             B_greater_A,
    output logic [SW-1:0]    slices,
    output logic             busy
);

    localparam int NS = WIDTH / 2;
    // Slice index needs at least one bit even when there is only one slice.
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [SW-1:0]    count;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;

    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic [1:0]       a_slice;
    logic [1:0]       b_slice;
    logic             cmp_eq;
    logic             cmp_agb;
    logic             cmp_bga;

    // Bring the current slice down to bit 0 so the comparator sees bits [2*idx+1:2*idx].
    always_comb begin
        a_shift = a_reg >> {idx, 1'b0};
        b_shift = b_reg >> {idx, 1'b0};
        a_slice = a_shift[1:0];
        b_slice = b_shift[1:0];
    end

    two_bit_comparator u_cmp (
        .A           (a_slice),
        .B           (b_slice),
        .A_equal_B   (cmp_eq),
        .A_greater_B (cmp_agb),
        .B_greater_A (cmp_bga)
    );

    // Accept is only possible in IDLE; held low while reset is asserted.
    assign start_ready = (state == IDLE) && !reset;

    // Sequencer FSM with registered result, handshake and busy outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= IW'(NS - 1);
            count       <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            A_equal_B   <= 1'b0;
            A_greater_B <= 1'b0;
            B_greater_A <= 1'b0;
            slices      <= '0;
            done_valid  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_reg <= A;
                        b_reg <= B;
                        idx   <= IW'(NS - 1);
                        count <= '0;
                        busy  <= 1'b1;
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
                    count <= count + 1'b1;
                    if (!cmp_eq) begin
                        A_equal_B   <= 1'b0;
                        A_greater_B <= cmp_agb;
                        B_greater_A <= cmp_bga;
                        slices      <= count + 1'b1;
                        done_valid  <= 1'b1;
                        state       <= DONE;
                    end else if (idx == '0) begin
                        // Every slice matched: operands are equal.
                        A_equal_B   <= 1'b1;
                        A_greater_B <= 1'b0;
                        B_greater_A <= 1'b0;
                        slices      <= SW'(NS);
                        done_valid  <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        done_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_compare_sequencer.sv
// Randomized self-checking bench for compare_sequencer (WIDTH = 8).
// Expected results come from plain integer comparison and a slice walk.

module tb_compare_sequencer;

    localparam int W  = 8;
    localparam int NS = W / 2;
    localparam int SW = $clog2(NS) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_valid;
    logic          start_ready;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          done_valid;
    logic          done_ready;
    logic          A_equal_B;
    logic          A_greater_B;
    logic          B_greater_A;
    logic [SW-1:0] slices;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    compare_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .A           (A),
        .B           (B),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .A_equal_B   (A_equal_B),
        .A_greater_B (A_greater_B),
        .B_greater_A (B_greater_A),
        .slices      (slices),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: flags by integer comparison; slice count by scanning from the top.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic eq, output logic agb, output logic bga, output int k);
        int av;
        int bv;
        av  = int'(a);
        bv  = int'(b);
        eq  = (av == bv);
        agb = (av > bv);
        bga = (bv > av);
        k   = 0;
        for (int s = NS - 1; s >= 0; s--) begin
            k++;
            if (((av >> (2 * s)) % 4) != ((bv >> (2 * s)) % 4)) break;
        end
    endtask

    task automatic check_result(input string tag, input logic eq, input logic agb,
                                input logic bga, input int k);
        check({tag, "_dv"},  32'(done_valid),  32'd1);
        check({tag, "_eq"},  32'(A_equal_B),   32'(eq));
        check({tag, "_agb"}, 32'(A_greater_B), 32'(agb));
        check({tag, "_bga"}, 32'(B_greater_A), 32'(bga));
        check({tag, "_sl"},  32'(slices),      32'(k));
        check({tag, "_sr"},  32'(start_ready), 32'd0);
        check({tag, "_bsy"}, 32'(busy),        32'd1);
    endtask

    // One full transaction: accept, wait for done, optionally stall, hand off.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold);
        logic eq, agb, bga;
        int   k;
        int   cyc;
        model(a, b, eq, agb, bga, k);
        check({tag, "_acc_sr"}, 32'(start_ready), 32'd1);
        A           = a;
        B           = b;
        start_valid = 1'b1;
        done_ready  = 1'b0;
        tick();
        check({tag, "_busy"}, 32'(busy), 32'd1);
        cyc = 0;
        do begin
            // Inputs are scrambled while busy; the latched operands must be used.
            A           = W'($urandom);
            B           = W'($urandom);
            start_valid = 1'($urandom);
            done_ready  = 1'($urandom);
            tick();
            cyc++;
        end while (!done_valid && cyc < NS + 3);
        check({tag, "_lat"}, 32'(cyc), 32'(k));
        check_result(tag, eq, agb, bga, k);
        done_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            A           = W'($urandom);
            B           = W'($urandom);
            start_valid = 1'($urandom);
            tick();
            check_result({tag, "_hold"}, eq, agb, bga, k);
        end
        start_valid = 1'b0;
        done_ready  = 1'b1;
        tick();
        done_ready = 1'b0;
        check({tag, "_ho_dv"}, 32'(done_valid),  32'd0);
        check({tag, "_ho_sr"}, 32'(start_ready), 32'd1);
        check({tag, "_ho_bs"}, 32'(busy),        32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dv"},  32'(done_valid),  32'd0);
        check({tag, "_eq"},  32'(A_equal_B),   32'd0);
        check({tag, "_agb"}, 32'(A_greater_B), 32'd0);
        check({tag, "_bga"}, 32'(B_greater_A), 32'd0);
        check({tag, "_sl"},  32'(slices),      32'd0);
        check({tag, "_bsy"}, 32'(busy),        32'd0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           nb;
        reset       = 1'b1;
        start_valid = 1'b0;
        done_ready  = 1'b0;
        A           = '0;
        B           = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_reset_vals("por");
        check("por_sr", 32'(start_ready), 32'd1);
        tick();

        run_op("c0_40", 8'hC0, 8'h40, 0);
        run_op("5a_5a", 8'h5A, 8'h5A, 0);
        run_op("12_13", 8'h12, 8'h13, 0);
        run_op("1f_2f", 8'h1F, 8'h2F, 0);
        run_op("stall", 8'h37, 8'h35, 5);
        run_op("zero",  8'h00, 8'h00, 0);
        run_op("max",   8'hFF, 8'h00, 1);
        run_op("min",   8'h00, 8'hFF, 0);

        // Abort two cycles into a compare of equal operands.
        A           = 8'h00;
        B           = 8'h00;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        tick();
        tick();
        check("abort_pre_bsy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_reset_vals("abort");
        tick();
        reset = 1'b0;
        #1;
        check("abort_sr", 32'(start_ready), 32'd1);
        for (int i = 0; i < NS + 1; i++) begin
            tick();
            check("abort_nodv", 32'(done_valid), 32'd0);
        end
        run_op("post_rst", 8'hA5, 8'hA4, 0);

        // Random operands biased so every slice count occurs.
        for (int n = 0; n < 150; n++) begin
            ra = W'($urandom);
            nb = int'($urandom_range(0, W));
            rb = ra ^ W'($urandom & ((32'd1 << nb) - 1));
            run_op("rnd", ra, rb, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
